// File: rtl/cpu_mem_pkg.sv
// Shared types and constants for the IF/DM memory port arbiter.
package cpu_mem_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_BUSY,
        ARB_RESP
    } arb_state_e;

    typedef enum logic {
        PORT_IF,
        PORT_DM
    } port_e;

    localparam int DEFAULT_TIMEOUT = 15;

endpackage

// File: rtl/mem_port_arbiter_wait_timer.sv
// Watchdog counter for a pending memory request: clears on a new grant,
// counts while enabled, saturates at LIMIT and flags expiry at LIMIT.
module wait_timer #(
    parameter int LIMIT = 15
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int CNT_W = $clog2(LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(LIMIT);

    logic [CNT_W-1:0] cnt;

    // Saturating wait counter; never wraps past LIMIT.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt <= '0;
        end else if (clr_i) begin
            cnt <= '0;
        end else if (en_i && (cnt != LIMIT_C)) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign expired_o = (cnt == LIMIT_C);

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-ported memory between the IF
// (fetch) and DM (data) requesters, with a watchdog and one-cycle acks.
module mem_port_arbiter
    import cpu_mem_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    output logic [31:0] if_rdata_o,
    output logic        if_ack_o,
    output logic        if_stall_o,
    input  logic        dm_req_i,
    input  logic        dm_we_i,
    input  logic [31:0] dm_addr_i,
    input  logic [31:0] dm_wdata_i,
    output logic [31:0] dm_rdata_o,
    output logic        dm_ack_o,
    output logic        dm_stall_o,
    output logic        err_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_ready_i
);

    arb_state_e state_q, state_d;
    port_e      grant_q, last_grant_q, win_port;
    logic       grant_load, ready_take, timeout_take;
    logic       err_q, busy, timer_expired;

    assign busy = (state_q == ARB_BUSY);

    wait_timer #(.LIMIT(TIMEOUT)) u_wait_timer (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clr_i     (grant_load),
        .en_i      (busy),
        .expired_o (timer_expired)
    );

    // FSM state register.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) state_q <= ARB_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic: arbitration in IDLE, completion/timeout in BUSY.
    always_comb begin
        state_d      = state_q;
        grant_load   = 1'b0;
        win_port     = PORT_IF;
        ready_take   = 1'b0;
        timeout_take = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (if_req_i || dm_req_i) begin
                    grant_load = 1'b1;
                    // On a tie the port that did not win last time goes first.
                    if (dm_req_i && (!if_req_i || (last_grant_q == PORT_IF)))
                        win_port = PORT_DM;
                    state_d = ARB_BUSY;
                end
            end
            ARB_BUSY: begin
                if (mem_ready_i) begin
                    ready_take = 1'b1;
                    state_d    = ARB_RESP;
                end else if (timer_expired) begin
                    timeout_take = 1'b1;
                    state_d      = ARB_RESP;
                end
            end
            ARB_RESP: state_d = ARB_IDLE;
            default:  state_d = ARB_IDLE;
        endcase
    end

    // Memory-side request registers, latched on grant and frozen while busy.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            mem_req_o    <= 1'b0;
            mem_we_o     <= 1'b0;
            mem_addr_o   <= '0;
            mem_wdata_o  <= '0;
            grant_q      <= PORT_IF;
            last_grant_q <= PORT_IF;
        end else if (grant_load) begin
            mem_req_o    <= 1'b1;
            mem_we_o     <= (win_port == PORT_DM) && dm_we_i;
            mem_addr_o   <= (win_port == PORT_DM) ? dm_addr_i : if_addr_i;
            mem_wdata_o  <= (win_port == PORT_DM) ? dm_wdata_i : '0;
            grant_q      <= win_port;
            last_grant_q <= win_port;
        end else if (ready_take || timeout_take) begin
            mem_req_o <= 1'b0;
        end
    end

    // Response registers: read data capture per port and the timeout flag.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            if_rdata_o <= '0;
            dm_rdata_o <= '0;
            err_q      <= 1'b0;
        end else begin
            if (ready_take && !mem_we_o) begin
                if (grant_q == PORT_IF) if_rdata_o <= mem_rdata_i;
                else                    dm_rdata_o <= mem_rdata_i;
            end
            if (timeout_take)                err_q <= 1'b1;
            else if (state_q == ARB_RESP)    err_q <= 1'b0;
        end
    end

    assign if_ack_o   = (state_q == ARB_RESP) && (grant_q == PORT_IF);
    assign dm_ack_o   = (state_q == ARB_RESP) && (grant_q == PORT_DM);
    assign err_o      = (state_q == ARB_RESP) && err_q;
    assign if_stall_o = if_req_i & ~if_ack_o;
    assign dm_stall_o = dm_req_i & ~dm_ack_o;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios followed by
// randomized transactions checked against a transaction-level model.
module tb_mem_port_arbiter;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst_i = 1'b0;
    logic        if_req_i = 1'b0;
    logic [31:0] if_addr_i = '0;
    logic [31:0] if_rdata_o;
    logic        if_ack_o, if_stall_o;
    logic        dm_req_i = 1'b0;
    logic        dm_we_i = 1'b0;
    logic [31:0] dm_addr_i = '0;
    logic [31:0] dm_wdata_i = '0;
    logic [31:0] dm_rdata_o;
    logic        dm_ack_o, dm_stall_o, err_o;
    logic        mem_req_o, mem_we_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic [31:0] mem_rdata_i = '0;
    logic        mem_ready_i = 1'b0;

    int n_cmp = 0;
    int n_fail = 0;

    // Reference model state: who won last, and what each port's rdata holds.
    bit          mdl_last_dm;
    logic [31:0] mdl_if_rd, mdl_dm_rd;

    mem_port_arbiter #(.TIMEOUT(TO)) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .if_req_i    (if_req_i),
        .if_addr_i   (if_addr_i),
        .if_rdata_o  (if_rdata_o),
        .if_ack_o    (if_ack_o),
        .if_stall_o  (if_stall_o),
        .dm_req_i    (dm_req_i),
        .dm_we_i     (dm_we_i),
        .dm_addr_i   (dm_addr_i),
        .dm_wdata_i  (dm_wdata_i),
        .dm_rdata_o  (dm_rdata_o),
        .dm_ack_o    (dm_ack_o),
        .dm_stall_o  (dm_stall_o),
        .err_o       (err_o),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_rdata_i (mem_rdata_i),
        .mem_ready_i (mem_ready_i)
    );

    always #5 clk = ~clk;

    function automatic void chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endfunction

    function automatic void chk1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endfunction

    function automatic void reset_model();
        mdl_last_dm = 1'b0;
        mdl_if_rd   = '0;
        mdl_dm_rd   = '0;
    endfunction

    // Runs one transaction from the currently driven requests. Called at a
    // falling edge of an idle cycle. k = cycle after grant in which memory
    // answers (1..), or 0 for a memory that never answers.
    task automatic do_one(input int k, input logic [31:0] rdat);
        bit          w_dm;
        bit          e_we;
        logic [31:0] e_addr;
        int          hi;
        int          exp_hi;
        w_dm   = dm_req_i && (!if_req_i || !mdl_last_dm);
        e_addr = w_dm ? dm_addr_i : if_addr_i;
        e_we   = w_dm && dm_we_i;
        exp_hi = (k == 0) ? TO + 1 : k;
        hi     = 0;
        @(negedge clk);
        while (mem_req_o === 1'b1 && hi < 40) begin
            hi++;
            chk32("busy_addr", mem_addr_o, e_addr);
            chk1("busy_we", mem_we_o, e_we);
            if (e_we) chk32("busy_wdata", mem_wdata_o, dm_wdata_i);
            chk1("busy_ack", if_ack_o | dm_ack_o, 1'b0);
            chk1("busy_stall", w_dm ? dm_stall_o : if_stall_o, 1'b1);
            if (hi == k) begin
                mem_ready_i = 1'b1;
                mem_rdata_i = rdat;
            end
            @(negedge clk);
            mem_ready_i = 1'b0;
            mem_rdata_i = $urandom;
        end
        chk32("req_cycles", hi, exp_hi);
        chk1("ack_if", if_ack_o, !w_dm);
        chk1("ack_dm", dm_ack_o, w_dm);
        chk1("ack_err", err_o, k == 0);
        if (k != 0 && !e_we) begin
            if (w_dm) mdl_dm_rd = rdat;
            else      mdl_if_rd = rdat;
        end
        chk32("if_rdata", if_rdata_o, mdl_if_rd);
        chk32("dm_rdata", dm_rdata_o, mdl_dm_rd);
        chk1("ack_stall", w_dm ? dm_stall_o : if_stall_o, 1'b0);
        mdl_last_dm = w_dm;
        if (w_dm) dm_req_i = 1'b0;
        else      if_req_i = 1'b0;
        @(negedge clk);
        chk1("post_ack", if_ack_o | dm_ack_o | err_o, 1'b0);
        chk1("post_req", mem_req_o, 1'b0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int pat;
        reset_model();
        // Reset state
        repeat (2) @(negedge clk);
        chk1("rst_req", mem_req_o, 1'b0);
        chk1("rst_we", mem_we_o, 1'b0);
        chk32("rst_addr", mem_addr_o, 32'h0);
        chk32("rst_wdata", mem_wdata_o, 32'h0);
        chk32("rst_if_rdata", if_rdata_o, 32'h0);
        chk32("rst_dm_rdata", dm_rdata_o, 32'h0);
        chk1("rst_acks", if_ack_o | dm_ack_o | err_o, 1'b0);
        rst_i = 1'b1;
        @(negedge clk);
        chk1("idle_req", mem_req_o, 1'b0);

        // Single fetch
        if_req_i  = 1'b1;
        if_addr_i = 32'h40;
        #1 chk1("fetch_stall_idle", if_stall_o, 1'b1);
        do_one(2, 32'h8C220004);
        chk32("fetch_data", if_rdata_o, 32'h8C220004);

        // Simultaneous requests: DM, IF, DM, IF
        if_req_i = 1'b1; if_addr_i = 32'h100;
        dm_req_i = 1'b1; dm_we_i = 1'b0; dm_addr_i = 32'h200;
        do_one(1, 32'hA0000001);
        do_one(3, 32'hA0000002);
        if_req_i = 1'b1; if_addr_i = 32'h104;
        dm_req_i = 1'b1; dm_addr_i = 32'h204;
        do_one(2, 32'hA0000003);
        do_one(1, 32'hA0000004);

        // Data write
        dm_req_i = 1'b1; dm_we_i = 1'b1; dm_addr_i = 32'h10; dm_wdata_i = 32'hDEADBEEF;
        do_one(2, 32'h55555555);
        dm_we_i = 1'b0;

        // Timeout, then a normal request
        dm_req_i = 1'b1; dm_addr_i = 32'h20;
        do_one(0, 32'h0);
        dm_req_i = 1'b1; dm_addr_i = 32'h24;
        do_one(1, 32'hC0FFEE00);
        // Ready arriving in the same cycle the watchdog would expire wins
        if_req_i = 1'b1; if_addr_i = 32'h28;
        do_one(TO + 1, 32'h0BADF00D);

        // Stray ready while idle
        mem_ready_i = 1'b1;
        mem_rdata_i = 32'h12345678;
        @(negedge clk);
        mem_ready_i = 1'b0;
        chk1("stray_ack", if_ack_o | dm_ack_o | err_o, 1'b0);
        chk1("stray_req", mem_req_o, 1'b0);
        chk32("stray_if_rdata", if_rdata_o, mdl_if_rd);
        chk32("stray_dm_rdata", dm_rdata_o, mdl_dm_rd);
        @(negedge clk);
        chk1("stray_ack2", if_ack_o | dm_ack_o | err_o, 1'b0);

        // Reset in the middle of a transaction
        dm_req_i = 1'b1; dm_addr_i = 32'h300;
        @(negedge clk);
        chk1("midrst_busy", mem_req_o, 1'b1);
        #2 rst_i = 1'b0;
        #1 chk1("midrst_req_async", mem_req_o, 1'b0);
        dm_req_i = 1'b0;
        @(negedge clk);
        chk1("midrst_ack", if_ack_o | dm_ack_o | err_o, 1'b0);
        rst_i = 1'b1;
        reset_model();
        @(negedge clk);
        chk1("midrst_idle", mem_req_o, 1'b0);
        chk1("midrst_ack2", if_ack_o | dm_ack_o, 1'b0);
        chk32("midrst_if_rdata", if_rdata_o, 32'h0);
        chk32("midrst_dm_rdata", dm_rdata_o, 32'h0);
        // After reset the DM port wins the first tie again
        if_req_i = 1'b1; if_addr_i = 32'h400;
        dm_req_i = 1'b1; dm_addr_i = 32'h500;
        do_one(1, 32'h11110000);
        do_one(1, 32'h22220000);

        // Randomized transactions
        for (int n = 0; n < 40; n++) begin
            pat = int'($urandom_range(1, 3));
            if (pat[0]) begin
                if_req_i  = 1'b1;
                if_addr_i = $urandom;
            end
            if (pat[1]) begin
                dm_req_i   = 1'b1;
                dm_we_i    = 1'($urandom_range(0, 1));
                dm_addr_i  = $urandom;
                dm_wdata_i = $urandom;
            end
            for (int j = 0; j < 2 && (if_req_i || dm_req_i); j++) begin
                if ($urandom_range(0, 7) == 0) do_one(0, 32'h0);
                else do_one(int'($urandom_range(1, TO + 1)), $urandom);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
